// File: rtl/q_meter.sv
// Resonator Q meter: excites the resonator, then counts ring-down periods between envelope thresholds.
// Optional feature macro Q_METER_AVERAGE_EN: four back-to-back measurements per start, averaged.
module q_meter #(
  parameter int unsigned BUS_WIDTH  = 10,
  parameter int unsigned EXC_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 osc_in,
  input  logic                 env_hi,
  input  logic                 env_lo,
  output logic                 excite,
  output logic                 busy,
  output logic                 ready,
  output logic                 timeout,
  output logic [BUS_WIDTH-1:0] q_measured
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = $clog2(EXC_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] EXC_LAST = EW'(EXC_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, EXCITE, WAIT_HI, COUNT, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic                 osc_prev_q, osc_prev_d;
  logic [EW-1:0]        exc_cnt_q, exc_cnt_d;
  logic [BUS_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 excite_q, excite_d, busy_q, busy_d;
  logic                 ready_q, ready_d, timeout_q, timeout_d;
  logic [BUS_WIDTH-1:0] q_q, q_d;
  logic                 osc_rise, env_hi_s, env_lo_s, active;
`ifdef Q_METER_AVERAGE_EN
  logic [BUS_WIDTH+1:0] sum_q, sum_d, sum_next;
  logic [1:0]           sub_q, sub_d;
`endif

  // Synchronizer bit order: {osc, env_hi, env_lo}
  assign sync1_d    = {osc_in, env_hi, env_lo};
  assign sync2_d    = sync1_q;
  assign osc_prev_d = sync2_q[2];
  assign osc_rise   = sync2_q[2] & ~osc_prev_q;
  assign env_hi_s   = sync2_q[1];
  assign env_lo_s   = sync2_q[0];
  assign active     = (state_q == EXCITE) || (state_q == WAIT_HI) || (state_q == COUNT);

  always_comb begin
    state_d   = state_q;
    exc_cnt_d = exc_cnt_q;
    per_cnt_d = per_cnt_q;
    to_cnt_d  = to_cnt_q;
    excite_d  = excite_q;
    ready_d   = ready_q;
    timeout_d = timeout_q;
    q_d       = q_q;
`ifdef Q_METER_AVERAGE_EN
    sum_d     = sum_q;
    sub_d     = sub_q;
    sum_next  = sum_q + {2'b00, per_cnt_q};
`endif
    if (active) to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = EXCITE;
          excite_d  = 1'b1;
          ready_d   = 1'b0;
          timeout_d = 1'b0;
          exc_cnt_d = '0;
          per_cnt_d = '0;
          to_cnt_d  = '0;
`ifdef Q_METER_AVERAGE_EN
          sum_d     = '0;
          sub_d     = '0;
`endif
        end
      end
      EXCITE: begin
        if (osc_rise) begin
          if (exc_cnt_q == EXC_LAST) begin
            state_d  = WAIT_HI;
            excite_d = 1'b0;
          end else begin
            exc_cnt_d = exc_cnt_q + 1'b1;
          end
        end
      end
      WAIT_HI: begin
        if (!env_hi_s) state_d = COUNT;
      end
      COUNT: begin
        if (!env_lo_s) begin
`ifdef Q_METER_AVERAGE_EN
          if (sub_q == 2'd3) begin
            state_d = DONE;
            ready_d = 1'b1;
            q_d     = sum_next[BUS_WIDTH+1:2];
          end else begin
            // Chain straight into the next sub-measurement with fresh counters
            sub_d     = sub_q + 1'b1;
            sum_d     = sum_next;
            state_d   = EXCITE;
            excite_d  = 1'b1;
            exc_cnt_d = '0;
            per_cnt_d = '0;
            to_cnt_d  = '0;
          end
`else
          state_d = DONE;
          ready_d = 1'b1;
          q_d     = per_cnt_q;
`endif
        end else if (osc_rise && (per_cnt_q != CNT_MAX)) begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout overrides whatever the state logic chose this cycle
    if (active && (to_cnt_q == TO_LAST)) begin
      state_d   = DONE;
      excite_d  = 1'b0;
      ready_d   = 1'b1;
      timeout_d = 1'b1;
      q_d       = '1;
    end

    busy_d = (state_d == EXCITE) || (state_d == WAIT_HI) || (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      osc_prev_q <= 1'b0;
      exc_cnt_q  <= '0;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      excite_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      q_q        <= '0;
`ifdef Q_METER_AVERAGE_EN
      sum_q      <= '0;
      sub_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      osc_prev_q <= osc_prev_d;
      exc_cnt_q  <= exc_cnt_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      excite_q   <= excite_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
      q_q        <= q_d;
`ifdef Q_METER_AVERAGE_EN
      sum_q      <= sum_d;
      sub_q      <= sub_d;
`endif
    end
  end

  assign excite     = excite_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign timeout    = timeout_q;
  assign q_measured = q_q;

endmodule
